// File: rtl/uart_pkg.sv
// uart_pkg: state encoding, data width and parity helper shared by uart_tx and uart_rx.
package uart_pkg;
   localparam int DATA_W = 8;
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
   function automatic logic par_calc(input logic [DATA_W-1:0] data, input logic typ);
      return typ ? ^data : ~^data;
   endfunction
endpackage

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: RX synchronizer, start-edge detect, per-bit edge counter and bit decision.
// UART_RX_MAJORITY_EN selects a 2-of-3 majority vote instead of a single mid-bit sample.
module uart_rx_sampler #(
   parameter int PRESCALE = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic rx,
   input  logic start,
   input  logic active,
   output logic sample_valid,
   output logic sample_bit,
   output logic bit_end,
   output logic fall_edge
);
   localparam int CW = $clog2(PRESCALE);
   logic [2:0]    sync;
   logic [CW-1:0] edge_cnt;
   always_ff @(posedge clk or negedge reset)
      if (!reset) sync <= '1;
      else sync <= {sync[1:0], rx};
   always_ff @(posedge clk or negedge reset)
      if (!reset) edge_cnt <= '0;
      else if (start) edge_cnt <= CW'(1);
      else if (active) edge_cnt <= (edge_cnt == CW'(PRESCALE - 1)) ? '0 : edge_cnt + CW'(1);
      else edge_cnt <= '0;
   assign fall_edge    = sync[2] & ~sync[1];
   assign sample_valid = active && edge_cnt == CW'(PRESCALE / 2 + 1);
   assign bit_end      = active && edge_cnt == CW'(PRESCALE - 1);
`ifdef UART_RX_MAJORITY_EN
   logic [1:0] early;
   always_ff @(posedge clk or negedge reset)
      if (!reset) early <= '1;
      else begin
         if (edge_cnt == CW'(PRESCALE / 2 - 1)) early[0] <= sync[1];
         if (edge_cnt == CW'(PRESCALE / 2)) early[1] <= sync[1];
      end
   assign sample_bit = (early[0] & early[1]) | (early[0] & sync[1]) | (early[1] & sync[1]);
`else
   assign sample_bit = sync[1];
`endif
endmodule

// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver with optional parity, error pulses and back-to-back frames.
// Build with UART_RX_MAJORITY_EN for majority-vote bit sampling.
module uart_rx
   import uart_pkg::*;
#(
   parameter int PRESCALE = 8,
   parameter int DATA_W   = uart_pkg::DATA_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              RX_IN,
   input  logic              PAR_EN,
   input  logic              PAR_TYP,
   output logic [DATA_W-1:0] P_DATA,
   output logic              DATA_VALID,
   output logic              PAR_ERR,
   output logic              STP_ERR,
   output logic              Busy
);
   state_t            state, next;
   logic              sample_valid, sample_bit, bit_end, fall_edge;
   logic [2:0]        bit_cnt;
   logic [DATA_W-1:0] data_reg;
   logic              par_en_l, par_typ_l, par_fail;
   uart_rx_sampler #(.PRESCALE(PRESCALE)) sampler (
      .clk(clk),
      .reset(reset),
      .rx(RX_IN),
      .start(state == IDLE && fall_edge),
      .active(state != IDLE),
      .sample_valid(sample_valid),
      .sample_bit(sample_bit),
      .bit_end(bit_end),
      .fall_edge(fall_edge)
   );
   assign Busy = state != IDLE;
   always_ff @(posedge clk or negedge reset)
      if (!reset) state <= IDLE;
      else state <= next;
   always_comb begin
      next = state;
      case (state)
         IDLE:    if (fall_edge) next = START;
         START:   if (sample_valid && sample_bit) next = IDLE;
                  else if (bit_end) next = DATA;
         DATA:    if (bit_end && bit_cnt == 3'(DATA_W - 1)) next = par_en_l ? PARITY : STOP;
         PARITY:  if (bit_end) next = STOP;
         STOP:    if (sample_valid) next = IDLE;
         default: next = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         P_DATA     <= '0;
         DATA_VALID <= 1'b0;
         PAR_ERR    <= 1'b0;
         STP_ERR    <= 1'b0;
         bit_cnt    <= '0;
         data_reg   <= '0;
         par_en_l   <= 1'b0;
         par_typ_l  <= 1'b0;
         par_fail   <= 1'b0;
      end else begin
         DATA_VALID <= 1'b0;
         PAR_ERR    <= 1'b0;
         STP_ERR    <= 1'b0;
         if (state == IDLE && fall_edge) begin
            par_en_l  <= PAR_EN;
            par_typ_l <= PAR_TYP;
            par_fail  <= 1'b0;
         end
         if (state == START && bit_end) bit_cnt <= '0;
         if (state == DATA && sample_valid) data_reg[bit_cnt] <= sample_bit;
         if (state == DATA && bit_end) bit_cnt <= bit_cnt + 3'd1;
         if (state == PARITY && sample_valid && sample_bit != par_calc(data_reg, par_typ_l))
            par_fail <= 1'b1;
         // Stop decision ends the frame early so a following start bit is never missed
         if (state == STOP && sample_valid) begin
            DATA_VALID <= sample_bit & ~par_fail;
            PAR_ERR    <= par_fail;
            STP_ERR    <= ~sample_bit;
            if (sample_bit && !par_fail) P_DATA <= data_reg;
         end
      end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frame tests for uart_rx at PRESCALE=8.
module tb_uart_rx;
   localparam int P = 8;
   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       RX_IN = 1'b1;
   logic       PAR_EN = 1'b0;
   logic       PAR_TYP = 1'b0;
   logic [7:0] P_DATA;
   logic       DATA_VALID, PAR_ERR, STP_ERR, Busy;
   int         checks = 0;
   int         errors = 0;
   int         pe_n = 0;
   int         se_n = 0;
   logic       busy_seen = 1'b0;
   logic [7:0] got[$];

   uart_rx #(.PRESCALE(P)) dut (
      .clk(clk),
      .reset(reset),
      .RX_IN(RX_IN),
      .PAR_EN(PAR_EN),
      .PAR_TYP(PAR_TYP),
      .P_DATA(P_DATA),
      .DATA_VALID(DATA_VALID),
      .PAR_ERR(PAR_ERR),
      .STP_ERR(STP_ERR),
      .Busy(Busy)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (DATA_VALID) got.push_back(P_DATA);
      if (PAR_ERR) pe_n++;
      if (STP_ERR) se_n++;
      if (Busy) busy_seen = 1'b1;
   end

   task automatic clear_counts();
      got.delete();
      pe_n = 0;
      se_n = 0;
      busy_seen = 1'b0;
   endtask

   task automatic drive_bit(input logic b);
      RX_IN = b;
      repeat (P) @(negedge clk);
   endtask

   task automatic idle(input int n);
      RX_IN = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic pe, input logic pb, input logic sb);
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(d[i]);
      if (pe) drive_bit(pb);
      drive_bit(sb);
   endtask

   task automatic test_reset();
      reset = 1'b0;
      RX_IN = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (P_DATA !== 8'h00) begin errors++; $display("FAIL reset_p_data got %h want 00", P_DATA); end
      checks++; if (DATA_VALID !== 1'b0) begin errors++; $display("FAIL reset_data_valid got %b want 0", DATA_VALID); end
      checks++; if (PAR_ERR !== 1'b0) begin errors++; $display("FAIL reset_par_err got %b want 0", PAR_ERR); end
      checks++; if (STP_ERR !== 1'b0) begin errors++; $display("FAIL reset_stp_err got %b want 0", STP_ERR); end
      checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", Busy); end
      reset = 1'b1;
      clear_counts();
      idle(10);
      checks++; if (busy_seen !== 1'b0) begin errors++; $display("FAIL idle_busy got %b want 0", busy_seen); end
   endtask

   task automatic test_good_frame();
      clear_counts();
      PAR_EN = 1'b0;
      send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
      idle(6);
      checks++; if (got.size() !== 1) begin errors++; $display("FAIL a5_valid_count got %0d want 1", got.size()); end
      checks++; if (P_DATA !== 8'hA5) begin errors++; $display("FAIL a5_p_data got %h want a5", P_DATA); end
      checks++; if (pe_n !== 0 || se_n !== 0) begin errors++; $display("FAIL a5_errors got pe=%0d se=%0d want 0 0", pe_n, se_n); end
      checks++; if (busy_seen !== 1'b1) begin errors++; $display("FAIL a5_busy_seen got %b want 1", busy_seen); end
      checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL a5_busy_end got %b want 0", Busy); end
   endtask

   task automatic test_parity();
      clear_counts();
      PAR_EN = 1'b1;
      PAR_TYP = 1'b0;
      send_frame(8'h3C, 1'b1, 1'b1, 1'b1);
      idle(6);
      checks++; if (got.size() !== 1) begin errors++; $display("FAIL par_ok_count got %0d want 1", got.size()); end
      checks++; if (P_DATA !== 8'h3C) begin errors++; $display("FAIL par_ok_p_data got %h want 3c", P_DATA); end
      checks++; if (pe_n !== 0) begin errors++; $display("FAIL par_ok_par_err got %0d want 0", pe_n); end
      clear_counts();
      fork
         send_frame(8'h3C, 1'b1, 1'b0, 1'b1);
         begin
            repeat (20) @(negedge clk);
            PAR_EN = 1'b0;
            PAR_TYP = 1'b1;
         end
      join
      idle(6);
      checks++; if (pe_n !== 1) begin errors++; $display("FAIL par_bad_par_err got %0d want 1", pe_n); end
      checks++; if (got.size() !== 0) begin errors++; $display("FAIL par_bad_valid got %0d want 0", got.size()); end
      checks++; if (P_DATA !== 8'h3C) begin errors++; $display("FAIL par_bad_p_data got %h want 3c", P_DATA); end
      checks++; if (se_n !== 0) begin errors++; $display("FAIL par_bad_stp_err got %0d want 0", se_n); end
   endtask

   task automatic test_stop_err();
      clear_counts();
      PAR_EN = 1'b1;
      PAR_TYP = 1'b1;
      send_frame(8'h81, 1'b1, 1'b0, 1'b0);
      idle(6);
      checks++; if (se_n !== 1) begin errors++; $display("FAIL stop_stp_err got %0d want 1", se_n); end
      checks++; if (pe_n !== 0) begin errors++; $display("FAIL stop_par_err got %0d want 0", pe_n); end
      checks++; if (got.size() !== 0) begin errors++; $display("FAIL stop_valid got %0d want 0", got.size()); end
      checks++; if (P_DATA !== 8'h3C) begin errors++; $display("FAIL stop_p_data got %h want 3c", P_DATA); end
   endtask

   task automatic test_glitch();
      clear_counts();
      PAR_EN = 1'b0;
      RX_IN = 1'b0;
      repeat (2) @(negedge clk);
      RX_IN = 1'b1;
      repeat (2) @(negedge clk);
      checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_start got %b want 1", Busy); end
      idle(20);
      checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_end got %b want 0", Busy); end
      checks++; if (got.size() !== 0 || pe_n !== 0 || se_n !== 0) begin errors++; $display("FAIL glitch_pulses got dv=%0d pe=%0d se=%0d want 0 0 0", got.size(), pe_n, se_n); end
      checks++; if (P_DATA !== 8'h3C) begin errors++; $display("FAIL glitch_p_data got %h want 3c", P_DATA); end
   endtask

   task automatic test_back_to_back();
      clear_counts();
      PAR_EN = 1'b0;
      send_frame(8'h55, 1'b0, 1'b0, 1'b1);
      send_frame(8'hFF, 1'b0, 1'b0, 1'b1);
      idle(6);
      checks++; if (got.size() !== 2) begin errors++; $display("FAIL b2b_count got %0d want 2", got.size()); end
      if (got.size() >= 2) begin
         checks++; if (got[0] !== 8'h55) begin errors++; $display("FAIL b2b_first got %h want 55", got[0]); end
         checks++; if (got[1] !== 8'hFF) begin errors++; $display("FAIL b2b_second got %h want ff", got[1]); end
      end
      checks++; if (pe_n !== 0 || se_n !== 0) begin errors++; $display("FAIL b2b_errors got pe=%0d se=%0d want 0 0", pe_n, se_n); end
   endtask

   task automatic test_reset_mid();
      logic [7:0] d;
      d = 8'h12;
      clear_counts();
      PAR_EN = 1'b0;
      drive_bit(1'b0);
      for (int i = 0; i < 4; i++) drive_bit(d[i]);
      RX_IN = d[4];
      repeat (4) @(negedge clk);
      reset = 1'b0;
      RX_IN = 1'b1;
      @(negedge clk);
      checks++; if (P_DATA !== 8'h00) begin errors++; $display("FAIL mid_reset_p_data got %h want 00", P_DATA); end
      checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL mid_reset_busy got %b want 0", Busy); end
      checks++; if ({DATA_VALID, PAR_ERR, STP_ERR} !== 3'b000) begin errors++; $display("FAIL mid_reset_pulses got %b want 000", {DATA_VALID, PAR_ERR, STP_ERR}); end
      repeat (2) @(negedge clk);
      reset = 1'b1;
      idle(5);
      send_frame(8'h34, 1'b0, 1'b0, 1'b1);
      idle(6);
      checks++; if (got.size() !== 1) begin errors++; $display("FAIL mid_count got %0d want 1", got.size()); end
      if (got.size() >= 1) begin
         checks++; if (got[0] !== 8'h34) begin errors++; $display("FAIL mid_data got %h want 34", got[0]); end
      end
      checks++; if (pe_n !== 0 || se_n !== 0) begin errors++; $display("FAIL mid_errors got pe=%0d se=%0d want 0 0", pe_n, se_n); end
   endtask

   initial begin
      test_reset();
      test_good_frame();
      test_parity();
      test_stop_err();
      test_glitch();
      test_back_to_back();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
